vdp_bus_responder: RTL and testbench

VDP_BUS_RESPONDER -- requirements
Module: vdp_bus_responder

---
 rtl/vdp_bus_pkg.sv | 34 +++
 rtl/vdp_bus_responder_if.sv | 20 ++
 rtl/vdp_reg_file.sv | 57 +++++
 rtl/vdp_bus_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_vdp_bus_responder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_bus_pkg.sv
// Shared types and constants for the VDP bus responder: FSM states, port
// selection and the fixed encodings seen on the host bus.
package vdp_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ACK      = 2'd3
    } vdp_state_e;

    typedef enum logic [1:0] {
        PORT_DATA = 2'd0,
        PORT_CTRL = 2'd1,
        PORT_HV   = 2'd2,
        PORT_NONE = 2'd3
    } vdp_port_e;

    localparam logic [1:0]  REG_WR_PREFIX = 2'b10;
    localparam logic [15:0] UNMAPPED_RD   = 16'hFFFF;

    // Port select comes from address bits [4:1]; bit 0 only picks a byte lane.
    function automatic vdp_port_e port_decode(input logic [3:0] sel);
        vdp_port_e port;
        case (sel)
            4'd0, 4'd1: port = PORT_DATA;
            4'd2, 4'd3: port = PORT_CTRL;
            4'd4:       port = PORT_HV;
            default:    port = PORT_NONE;
        endcase
        return port;
    endfunction

endpackage

// File: rtl/vdp_bus_responder_if.sv
// Host-side VDP bus: select/read-not-write/address/data towards the
// responder, read data and active-low DTACK back to the initiator.
interface vdp_bus_responder_if;
    logic        vdp_sel;
    logic        vdp_rnw;
    logic [4:0]  vdp_a;
    logic [15:0] vdp_di;
    logic [15:0] vdp_do;
    logic        vdp_dtack_n;

    modport master (
        output vdp_sel, vdp_rnw, vdp_a, vdp_di,
        input  vdp_do, vdp_dtack_n
    );

    modport slave (
        input  vdp_sel, vdp_rnw, vdp_a, vdp_di,
        output vdp_do, vdp_dtack_n
    );
endinterface

// File: rtl/vdp_reg_file.sv
// NUM_REGS x 8-bit VDP register file: one synchronous write port and two
// combinational read ports; out-of-range indices write nothing and read 0.
module vdp_reg_file #(
    parameter int NUM_REGS = 24
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [4:0] raddr_b,
    output logic [7:0] rdata_b
);

    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];

    function automatic logic idx_ok(input logic [4:0] idx);
        return ({27'd0, idx} < NUM_REGS);
    endfunction

    // Next register contents: at most one byte changes per cycle.
    always_comb begin
        regs_d = regs_q;
        if (we && idx_ok(waddr)) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (srst) begin
            regs_q <= '{default: 8'h00};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports.
    always_comb begin
        if (idx_ok(raddr_a)) begin
            rdata_a = regs_q[raddr_a];
        end else begin
            rdata_a = 8'h00;
        end
        if (idx_ok(raddr_b)) begin
            rdata_b = regs_q[raddr_b];
        end else begin
            rdata_b = 8'h00;
        end
    end

endmodule

// File: rtl/vdp_bus_responder.sv
// VDP host bus responder: decodes data/control/HV ports, runs VRAM accesses
// with a timeout, and acknowledges with DTACK. HV port built with VDP_HVCNT_EN.
module vdp_bus_responder
    import vdp_bus_pkg::*;
#(
    parameter int NUM_REGS    = 24,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 srst,
    vdp_bus_responder_if.slave   bus,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [15:0]          mem_addr,
    output logic [3:0]           mem_code,
    output logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata,
    input  logic                 mem_ack,
    input  logic [15:0]          status_in,
    input  logic [15:0]          hv_count,
    input  logic [4:0]           cfg_idx,
    output logic [7:0]           cfg_data
);

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    vdp_state_e  state_q, state_d;
    logic [3:0]  a_q, a_d;
    logic        rnw_q, rnw_d;
    logic [15:0] di_q, di_d;
    logic [15:0] do_q, do_d;
    logic        dtack_n_q, dtack_n_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_code_q, mem_code_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] addr_q, addr_d;
    logic [3:0]  code_q, code_d;
    logic        pending_q, pending_d;
    logic [15:0] tmo_q, tmo_d;

    logic        reg_we_s;
    logic [7:0]  inc_s;
    logic [15:0] hv_rd_s;
    logic        unused_s;

`ifdef VDP_HVCNT_EN
    assign hv_rd_s  = hv_count;
    assign unused_s = bus.vdp_a[0];
`else
    assign hv_rd_s  = UNMAPPED_RD;
    assign unused_s = ^{bus.vdp_a[0], hv_count};
`endif

    vdp_reg_file #(
        .NUM_REGS (NUM_REGS)
    ) u_regs (
        .clk     (clk),
        .srst    (srst),
        .we      (reg_we_s),
        .waddr   (di_q[12:8]),
        .wdata   (di_q[7:0]),
        .raddr_a (5'd15),
        .rdata_a (inc_s),
        .raddr_b (cfg_idx),
        .rdata_b (cfg_data)
    );

    // Next-state and output decode for the access FSM.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        rnw_d       = rnw_q;
        di_d        = di_q;
        do_d        = do_q;
        dtack_n_d   = 1'b1;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_code_d  = mem_code_q;
        mem_wdata_d = mem_wdata_q;
        addr_d      = addr_q;
        code_d      = code_q;
        pending_d   = pending_q;
        tmo_d       = tmo_q;
        reg_we_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.vdp_sel) begin
                    a_d     = bus.vdp_a[4:1];
                    rnw_d   = bus.vdp_rnw;
                    di_d    = bus.vdp_di;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DECODE: begin
                state_d   = ST_ACK;
                dtack_n_d = 1'b0;
                case (port_decode(a_q))
                    PORT_DATA: begin
                        state_d     = ST_MEM_WAIT;
                        dtack_n_d   = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = !rnw_q;
                        mem_addr_d  = addr_q;
                        mem_code_d  = code_q;
                        mem_wdata_d = rnw_q ? mem_wdata_q : di_q;
                        tmo_d       = 16'd0;
                    end
                    PORT_CTRL: begin
                        // Register writes only take the prefix path when no
                        // command word is half-written.
                        if (rnw_q) begin
                            do_d      = status_in;
                            pending_d = 1'b0;
                        end else if (!pending_q && (di_q[15:14] == REG_WR_PREFIX)) begin
                            reg_we_s  = 1'b1;
                        end else if (!pending_q) begin
                            addr_d[13:0] = di_q[13:0];
                            code_d[1:0]  = di_q[15:14];
                            pending_d    = 1'b1;
                        end else begin
                            addr_d[15:14] = di_q[1:0];
                            code_d[3:2]   = di_q[5:4];
                            pending_d     = 1'b0;
                        end
                    end
                    PORT_HV: begin
                        do_d = rnw_q ? hv_rd_s : do_q;
                    end
                    default: begin
                        do_d = rnw_q ? UNMAPPED_RD : do_q;
                    end
                endcase
            end

            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    do_d      = rnw_q ? mem_rdata : do_q;
                    addr_d    = addr_q + {8'h00, inc_s};
                    pending_d = 1'b0;
                    mem_req_d = 1'b0;
                    state_d   = ST_ACK;
                    dtack_n_d = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    do_d      = rnw_q ? UNMAPPED_RD : do_q;
                    mem_req_d = 1'b0;
                    state_d   = ST_ACK;
                    dtack_n_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            ST_ACK: begin
                if (!bus.vdp_sel) begin
                    state_d   = ST_IDLE;
                    dtack_n_d = 1'b1;
                end else begin
                    state_d   = ST_ACK;
                    dtack_n_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            a_q         <= 4'd0;
            rnw_q       <= 1'b0;
            di_q        <= 16'h0000;
            do_q        <= 16'h0000;
            dtack_n_q   <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_code_q  <= 4'd0;
            mem_wdata_q <= 16'h0000;
            addr_q      <= 16'h0000;
            code_q      <= 4'd0;
            pending_q   <= 1'b0;
            tmo_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            rnw_q       <= rnw_d;
            di_q        <= di_d;
            do_q        <= do_d;
            dtack_n_q   <= dtack_n_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_code_q  <= mem_code_d;
            mem_wdata_q <= mem_wdata_d;
            addr_q      <= addr_d;
            code_q      <= code_d;
            pending_q   <= pending_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.vdp_do      = do_q;
    assign bus.vdp_dtack_n = dtack_n_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_code        = mem_code_q;
    assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_vdp_bus_responder.sv
// Directed bench for vdp_bus_responder: read data is scoreboarded through a
// queue of expected values, checked when DTACK falls. Honours VDP_HVCNT_EN.
module tb_vdp_bus_responder;

`ifdef VDP_HVCNT_EN
    localparam logic [15:0] HV_EXP = 16'h1357;
`else
    localparam logic [15:0] HV_EXP = 16'hFFFF;
`endif
    localparam logic [15:0] STATUS = 16'hA5C3;

    logic        clk = 1'b0;
    logic        srst;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_code;
    logic [15:0] status_in, hv_count;
    logic [4:0]  cfg_idx;
    logic [7:0]  cfg_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    int          lat;
    int          cap_req_cycles;
    logic        cap_we;
    logic [15:0] cap_addr, cap_wdata;
    logic [3:0]  cap_code;

    vdp_bus_responder_if bus ();

    vdp_bus_responder dut (
        .clk       (clk),
        .srst      (srst),
        .bus       (bus),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_code  (mem_code),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .status_in (status_in),
        .hv_count  (hv_count),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus access; ack_dly < 0 means memory never acknowledges.
    task automatic access(input logic rnw, input logic [4:0] a, input logic [15:0] di,
                          input logic [15:0] exp_do, input int ack_dly,
                          input logic [15:0] rdata, input bit short_sel);
        int  req_cyc;
        bit  done;
        logic [15:0] exp;
        if (rnw) exp_q.push_back(exp_do);
        mem_rdata      = rdata;
        req_cyc        = 0;
        done           = 1'b0;
        lat            = 0;
        cap_req_cycles = 0;
        bus.vdp_sel    = 1'b1;
        bus.vdp_rnw    = rnw;
        bus.vdp_a      = a;
        bus.vdp_di     = di;
        while (!done && lat < 400) begin
            tick();
            lat++;
            if (short_sel) bus.vdp_sel = 1'b0;
            if (mem_req) begin
                if (req_cyc == 0) begin
                    cap_we    = mem_we;
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                    cap_code  = mem_code;
                end
                req_cyc++;
            end
            mem_ack = mem_req && (ack_dly >= 0) && (req_cyc == ack_dly);
            if (!bus.vdp_dtack_n) done = 1'b1;
        end
        mem_ack        = 1'b0;
        cap_req_cycles = req_cyc;
        check("dtack_seen", {31'd0, done}, 32'd1);
        if (rnw) begin
            exp = exp_q.pop_front();
            if (done) check("rd_data", {16'd0, bus.vdp_do}, {16'd0, exp});
        end
        if (!short_sel && done) begin
            tick();
            check("dtack_hold", {31'd0, bus.vdp_dtack_n}, 32'd0);
            bus.vdp_sel = 1'b0;
        end
        tick();
        check("dtack_release", {31'd0, bus.vdp_dtack_n}, 32'd1);
    endtask

    initial begin
        srst        = 1'b1;
        bus.vdp_sel = 1'b0;
        bus.vdp_rnw = 1'b0;
        bus.vdp_a   = 5'd0;
        bus.vdp_di  = 16'h0000;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        status_in   = STATUS;
        hv_count    = 16'h1357;
        cfg_idx     = 5'd15;
        tick();
        tick();
        srst = 1'b0;
        check("rst_dtack", {31'd0, bus.vdp_dtack_n}, 32'd1);
        check("rst_do", {16'd0, bus.vdp_do}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_reg15", {24'd0, cfg_data}, 32'd0);

        // Register write to reg[15] sets the address increment.
        access(1'b0, 5'h04, 16'h8F02, 16'h0000, -1, 16'h0000, 1'b0);
        check("regwr_lat", lat, 32'd2);
        check("reg15", {24'd0, cfg_data}, 32'h02);
        check("regwr_pending", {31'd0, dut.pending_q}, 32'd0);

        // Two-word command.
        access(1'b0, 5'h04, 16'h4123, 16'h0000, -1, 16'h0000, 1'b0);
        check("cmd1_pending", {31'd0, dut.pending_q}, 32'd1);
        access(1'b0, 5'h06, 16'h0010, 16'h0000, -1, 16'h0000, 1'b0);
        check("cmd_addr", {16'd0, dut.addr_q}, 32'h0123);
        check("cmd_code", {28'd0, dut.code_q}, 32'h5);
        check("cmd2_pending", {31'd0, dut.pending_q}, 32'd0);

        // Data write, ack after 3 cycles.
        access(1'b0, 5'h00, 16'hBEEF, 16'h0000, 3, 16'h0000, 1'b0);
        check("wr_lat", lat, 32'd5);
        check("wr_we", {31'd0, cap_we}, 32'd1);
        check("wr_addr", {16'd0, cap_addr}, 32'h0123);
        check("wr_wdata", {16'd0, cap_wdata}, 32'hBEEF);
        check("wr_code", {28'd0, cap_code}, 32'h5);
        check("wr_addr_inc", {16'd0, dut.addr_q}, 32'h0125);

        // Data read, ack after 5 cycles.
        access(1'b1, 5'h01, 16'h0000, 16'h1234, 5, 16'h1234, 1'b0);
        check("rd_lat", lat, 32'd7);
        check("rd_we", {31'd0, cap_we}, 32'd0);
        check("rd_addr", {16'd0, cap_addr}, 32'h0125);
        check("rd_addr_inc", {16'd0, dut.addr_q}, 32'h0127);

        // Data read with no ack: timeout.
        access(1'b1, 5'h00, 16'h0000, 16'hFFFF, -1, 16'h5555, 1'b0);
        check("tmo_lat", lat, 32'd257);
        check("tmo_req_cycles", cap_req_cycles, 32'd255);
        check("tmo_addr_kept", {16'd0, dut.addr_q}, 32'h0127);
        check("tmo_mem_req", {31'd0, mem_req}, 32'd0);

        // First command half, then status read clears pending.
        access(1'b0, 5'h04, 16'h4000, 16'h0000, -1, 16'h0000, 1'b0);
        check("half_pending", {31'd0, dut.pending_q}, 32'd1);
        access(1'b1, 5'h05, 16'h0000, STATUS, -1, 16'h0000, 1'b0);
        check("status_pending", {31'd0, dut.pending_q}, 32'd0);
        access(1'b0, 5'h04, 16'h8105, 16'h0000, -1, 16'h0000, 1'b0);
        cfg_idx = 5'd1;
        #1;
        check("reg1", {24'd0, cfg_data}, 32'h05);

        // Highest valid register, and an index beyond NUM_REGS.
        access(1'b0, 5'h04, 16'h9755, 16'h0000, -1, 16'h0000, 1'b0);
        access(1'b0, 5'h04, 16'h9E77, 16'h0000, -1, 16'h0000, 1'b0);
        cfg_idx = 5'd23;
        #1;
        check("reg23", {24'd0, cfg_data}, 32'h55);
        cfg_idx = 5'd30;
        #1;
        check("reg30_oob", {24'd0, cfg_data}, 32'h00);

        // Unmapped and HV ports.
        access(1'b1, 5'h0A, 16'h0000, 16'hFFFF, -1, 16'h0000, 1'b0);
        access(1'b0, 5'h1F, 16'h4321, 16'h0000, -1, 16'h0000, 1'b0);
        check("unmapped_wr", {31'd0, dut.pending_q}, 32'd0);
        access(1'b1, 5'h08, 16'h0000, HV_EXP, -1, 16'h0000, 1'b0);

        // Select dropped before ACK: one-cycle ACK.
        access(1'b1, 5'h06, 16'h0000, STATUS, -1, 16'h0000, 1'b1);
        check("short_lat", lat, 32'd2);

        // Reset in the middle of a memory wait.
        cfg_idx     = 5'd15;
        bus.vdp_sel = 1'b1;
        bus.vdp_rnw = 1'b1;
        bus.vdp_a   = 5'h00;
        repeat (6) tick();
        check("mw_req", {31'd0, mem_req}, 32'd1);
        srst = 1'b1;
        tick();
        srst        = 1'b0;
        bus.vdp_sel = 1'b0;
        check("mrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("mrst_dtack", {31'd0, bus.vdp_dtack_n}, 32'd1);
        check("mrst_do", {16'd0, bus.vdp_do}, 32'd0);
        check("mrst_reg15", {24'd0, cfg_data}, 32'd0);
        check("mrst_addr", {16'd0, dut.addr_q}, 32'd0);
        check("mrst_mem_addr", {16'd0, mem_addr}, 32'd0);
        tick();
        check("mrst_idle_dtack", {31'd0, bus.vdp_dtack_n}, 32'd1);
        access(1'b1, 5'h09, 16'h0000, HV_EXP, -1, 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
